// File: rtl/mem_align_unit_pkg.sv
// rtl/mem_align_unit_pkg.sv - opcode, FSM state and lane definitions for the load/store align unit
package mem_align_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    // SZ_NONE marks any opcode that is not a load/store
    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic op_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [LANES-1:0] lane_be(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Narrow stores replicate the source across every lane; byte enables pick the live one
    function automatic logic [WORD_W-1:0] store_lanes(input size_e sz, input logic [WORD_W-1:0] src);
        case (sz)
            SZ_BYTE: return {LANES{src[LANE_W-1:0]}};
            SZ_HALF: return {2{src[HALF_W-1:0]}};
            default: return src;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit_load_extract.sv
// rtl/mem_align_unit_load_extract.sv - lane select and sign/zero extension of load data
module load_extract
    import mem_align_unit_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [1:0]        offset,
    input  logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] data
);

    logic [LANE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;
    logic              sgn;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: LANE_W];
        lane_h = rdata[{offset[1], 4'b0000} +: HALF_W];
        sgn    = op_signed(opcode);
        data   = rdata;
        case (op_size(opcode))
            SZ_BYTE: data = {{(WORD_W-LANE_W){sgn & lane_b[LANE_W-1]}}, lane_b};
            SZ_HALF: data = {{(WORD_W-HALF_W){sgn & lane_h[HALF_W-1]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - MEM-stage load/store alignment and data-memory handshake
module mem_align_unit
    import mem_align_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [5:0]        OpCode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              addr_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [31:0]       extract_data;
    size_e             req_size;
    logic              misaligned;
    logic              mem_op;

    assign req_size   = op_size(OpCode);
    assign mem_op     = req_valid && (req_size != SZ_NONE) && !rst;
    assign misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                        ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));

    load_extract u_extract (
        .opcode (op_q),
        .offset (addr_q[1:0]),
        .rdata  (mem_rdata),
        .data   (extract_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        load_data_d = load_data_q;
        stall       = 1'b0;
        addr_err    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        load_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        addr_err = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        op_d    = OpCode;
                        addr_d  = addr;
                        wdata_d = store_lanes(req_size, wdata);
                        be_d    = lane_be(req_size, addr[1:0]);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = op_store(op_q);
                if (mem_gnt) begin
                    state_d = op_store(op_q) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    load_data_d = extract_data;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                load_valid = !op_store(op_q);
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            load_data_q <= load_data_d;
        end
    end

    assign mem_be    = (state_q == ST_REQ) ? be_q : 4'b0000;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - self-checking bench for mem_align_unit
module tb_mem_align_unit;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [5:0]  OpCode;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, addr_err, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] load_data, mem_wdata, mem_rdata, mem_addr;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_align_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .OpCode(OpCode), .addr(addr),
        .wdata(wdata), .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .addr_err(addr_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    logic        e_stall = 0, e_req = 0, e_we = 0, e_lvalid = 0, e_err = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ldata = 0;
    logic        chk_on = 0;
    int          req_cycles = 0, err_cnt = 0;
    logic [3:0]  st_be = 0;
    logic [31:0] st_wdata = 0, st_addr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_size(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LW || op == SW) return 4;
        return 0;
    endfunction

    function automatic logic m_store(input logic [5:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] b;
        b = ((32'd1 << m_size(op)) - 32'd1) << (a % 4);
        return b[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] w);
        if (m_size(op) == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (m_size(op) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
        longint r, v, full;
        int n;
        n    = m_size(op);
        r    = longint'(rd);
        full = longint'(1) << (8 * n);
        v    = (r >> (8 * (a % 4))) % full;
        if ((op == LB || op == LH) && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", stall, e_stall);
            chk("mem_req", mem_req, e_req);
            chk("mem_we", mem_we, e_we);
            chk("load_valid", load_valid, e_lvalid);
            chk("addr_err", addr_err, e_err);
            chk("load_data", load_data, e_ldata);
            if (e_req) chk("mem_addr", mem_addr, e_addr);
            if (e_req && e_we) begin
                chk("mem_be", mem_be, e_be);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (rst) begin
                chk("rst_mem_be", mem_be, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
            end
            if (mem_req) req_cycles++;
            if (addr_err) err_cnt++;
            if (mem_req && mem_we) begin
                st_be = mem_be; st_wdata = mem_wdata; st_addr = mem_addr;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_stall = 0; e_req = 0; e_we = 0; e_lvalid = 0; e_err = 0;
    endtask

    task automatic noise();
        mem_gnt = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            req_valid = 0; OpCode = 6'($urandom); noise();
            idle_exp();
        end
    endtask

    // Issues one MEM-stage instruction and plays the memory side; returns inside the last cycle
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] rd, input int gd, input int rdly);
        int n;
        logic st;
        n  = m_size(op);
        st = m_store(op);
        cyc();
        req_valid = 1; OpCode = op; addr = a; wdata = w; noise();
        idle_exp();
        if (n == 0) return;
        if (a % n != 0) begin
            e_err = 1;
            return;
        end
        e_stall = 1;
        for (int i = 0; i <= gd; i++) begin
            cyc();
            mem_gnt = (i == gd); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            idle_exp();
            e_stall = 1; e_req = 1; e_we = st;
            e_be = m_be(op, a); e_addr = a & ~32'd3; e_wdata = m_wdata(op, w);
        end
        if (!st) begin
            for (int j = 0; j <= rdly; j++) begin
                cyc();
                mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = (j == rdly);
                mem_rdata = (j == rdly) ? rd : $urandom;
                idle_exp();
                e_stall = 1;
            end
        end
        cyc();
        noise();
        idle_exp();
        e_lvalid = !st;
        if (!st) e_ldata = m_load(op, a, rd);
    endtask

    logic [5:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    initial begin
        int rc0, ec0;
        logic [5:0] op;
        logic [31:0] a;
        rst = 1; req_valid = 0; OpCode = 0; addr = 0; wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        chk("model_lb", m_load(LB, 32'h1003, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("model_lhu", m_load(LHU, 32'h2002, 32'hBEEF_0000), 32'h0000_BEEF);
        chk("model_sh_be", m_be(SH, 32'h3002), 32'h0000_000C);
        chk("model_sh_wd", m_wdata(SH, 32'h1234_ABCD), 32'hABCD_ABCD);

        chk_on = 1;
        cyc(); cyc();
        rst = 0;
        gap(2);

        do_op(LB, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0);
        @(negedge clk); #1;
        chk("lb_data", load_data, 32'hFFFF_FF80);
        chk("lb_valid", load_valid, 1);
        gap(1);
        do_op(LHU, 32'h2002, 32'h0, 32'hBEEF_0000, 1, 2);
        @(negedge clk); #1;
        chk("lhu_data", load_data, 32'h0000_BEEF);
        gap(1);

        do_op(SH, 32'h3002, 32'h1234_ABCD, 32'h0, 0, 0);
        gap(1);
        chk("sh_be", st_be, 32'h0000_000C);
        chk("sh_wdata", st_wdata, 32'hABCD_ABCD);
        chk("sh_addr", st_addr, 32'h0000_3000);

        rc0 = req_cycles; ec0 = err_cnt;
        do_op(LW, 32'h4001, 32'h0, 32'h0, 0, 0);
        gap(2);
        chk("lw_mis_err", 32'(err_cnt - ec0), 1);
        chk("lw_mis_noreq", 32'(req_cycles - rc0), 0);

        rc0 = req_cycles;
        do_op(SW, 32'h5004, 32'hCAFE_F00D, 32'h0, 5, 0);
        gap(1);
        chk("sw_req_cycles", 32'(req_cycles - rc0), 6);

        cyc();
        req_valid = 1; OpCode = LW; addr = 32'h6000; mem_gnt = 0; mem_rvalid = 0;
        idle_exp(); e_stall = 1;
        cyc();
        mem_gnt = 1;
        idle_exp(); e_stall = 1; e_req = 1; e_addr = 32'h6000;
        cyc();
        mem_gnt = 0;
        idle_exp(); e_stall = 1;
        #2;
        rst = 1; req_valid = 0;
        idle_exp(); e_ldata = 0;
        cyc();
        cyc();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        cyc();
        mem_rvalid = 1;
        @(negedge clk); #1;
        chk("rst_wait_lvalid", load_valid, 0);
        chk("rst_wait_stall", stall, 0);
        gap(1);

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            do_op(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            gap($urandom_range(0, 2));
        end
        gap(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_align_unit.md
MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  MEM stage holds a load/store.
REQ-005 SHALL have port OpCode  input  6  MIPS opcode of MEM-stage instruction.
REQ-006 SHALL have port addr  input  ADDR_W  effective byte address.
REQ-007 SHALL have port wdata  input  32  store source register value.
REQ-008 SHALL have port stall  output  1  pipeline must hold MEM-stage inputs stable.
REQ-009 SHALL have port load_data  output  32  extended load result.
REQ-010 SHALL have port load_valid  output  1  load_data valid this cycle.
REQ-011 SHALL have port addr_err  output  1  misaligned-access pulse.
REQ-012 SHALL have ports mem_req, mem_we (output 1), mem_be (output 4), mem_addr (output ADDR_W), mem_wdata (output 32), mem_gnt, mem_rvalid (input 1), mem_rdata (input 32) to data memory.

Function
REQ-013 SHALL decode lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011; any other OpCode with req_valid=1 is a no-op, no stall.
REQ-014 SHALL use little-endian lanes: byte offset k = addr[1:0] maps to mem_rdata/mem_wdata bits [8k+7:8k], mem_be bit k.
REQ-015 SHALL run FSM IDLE, REQ, WAIT, DONE.
REQ-016 IDLE: valid aligned op -> register op/addr/data, stall=1, next REQ.
REQ-017 Misalignment (half: addr[0]=1; word: addr[1:0]!=0) in IDLE -> addr_err=1 for that cycle, stall=0, no memory access, stay IDLE.
REQ-018 REQ: mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}; held until mem_gnt=1; on grant store -> DONE, load -> WAIT.
REQ-019 Stores: sb replicates wdata[7:0] to all lanes, be=1<<k; sh replicates wdata[15:0] to both halves, be=4'b0011 or 4'b1100; sw be=4'b1111; mem_we=1 only in REQ for stores.
REQ-020 WAIT: on mem_rvalid -> register selected lane, sign-extend (lb, lh) or zero-extend (lbu, lhu), lw passthrough, into load_data; next DONE.
REQ-021 DONE: stall=0, load_valid=1 for loads only, exactly one cycle; next IDLE unconditionally (req_valid ignored in DONE).
REQ-022 stall=1 in REQ and WAIT, and in IDLE when accepting; else 0.
REQ-023 mem_rvalid outside WAIT SHALL be ignored; mem_gnt outside REQ ignored.
REQ-024 load_data SHALL hold its last value until the next load completes.
REQ-025 Minimum latency: store 3 cycles (accept, REQ with gnt, DONE); load 4 cycles with gnt and rvalid in successive cycles.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, stall=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0, load_valid=0, addr_err=0.
REQ-027 Reset mid-operation SHALL abandon the access; a later rvalid for it is ignored.

Structure
REQ-028 Opcode constants, FSM state encoding and lane-width constants SHALL live in a shared package used by the decoder and extend unit.
REQ-029 Lane select plus sign/zero extension SHALL be a combinational sub-module load_extract.

Verification
REQ-030 lb addr=0x1003, mem_rdata=0x80FF_1234 -> load_data=0xFFFF_FF80, load_valid one cycle.
REQ-031 lhu addr=0x2002, mem_rdata=0xBEEF_0000 -> load_data=0x0000_BEEF.
REQ-032 sh addr=0x3002, wdata=0x1234_ABCD -> mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1, mem_addr=0x3000.
REQ-033 lw addr=0x4001 -> addr_err=1 one cycle, mem_req never asserted, stall=0.
REQ-034 sw with mem_gnt held low 5 cycles -> mem_req and stall held 5 cycles, DONE one cycle after grant.
REQ-035 rst asserted in WAIT, then mem_rvalid=1 -> IDLE, load_valid stays 0.
